// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package hazard_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  localparam int                REG_W    = 5;
  localparam logic [REG_W-1:0]  ZERO_REG = 5'd0;
  localparam int                TMR_W    = 16;

endpackage

// File: rtl/hazard_stall_unit_sat_counter.sv
// Saturating up-counter used for the stall and flush performance counters.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/hazard_stall_unit.sv
// Stall/bubble/flush controller for the 5-stage pipeline: load-use, taken branch, dmem wait.
//   state    | meaning
//   RUN      | pipeline advancing; hazards resolved combinationally
//   MEM_WAIT | data memory stalled; whole pipeline frozen until dmem_ready
module hazard_stall_unit
  import hazard_pkg::*;
#(
  parameter int COUNT_W  = 16,
  parameter int WAIT_MAX = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [REG_W-1:0]   ID_rs1,
  input  logic [REG_W-1:0]   ID_rs2,
  input  logic               ID_use_rs1,
  input  logic               ID_use_rs2,
  input  logic               EX_MemRead,
  input  logic [REG_W-1:0]   EX_rd,
  input  logic               EX_BranchTaken,
  input  logic               MEM_Req,
  input  logic               dmem_ready,
  output logic               PC_Write,
  output logic               IFID_Write,
  output logic               IFID_Flush,
  output logic               IDEX_Flush,
  output logic               EXMEM_Write,
  output logic               MEMWB_Write,
  output logic               mem_timeout,
  output logic [COUNT_W-1:0] stall_cnt,
  output logic [COUNT_W-1:0] flush_cnt
);

  localparam logic [TMR_W-1:0] WAIT_LIM = TMR_W'(WAIT_MAX);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [TMR_W-1:0]  r_wait_cnt;
  logic [TMR_W-1:0]  w_wait_inc;
  logic              r_mem_timeout;
  logic              w_mem_hold;
  logic              w_load_use;
  logic              w_stall_inc;
  logic              w_flush_inc;

  assign w_mem_hold = MEM_Req & ~dmem_ready;
  assign w_load_use = EX_MemRead & (EX_rd != ZERO_REG) &
                      ((ID_use_rs1 & (ID_rs1 == EX_rd)) |
                       (ID_use_rs2 & (ID_rs2 == EX_rd)));

  // Branch squashes the ID instruction, so a coincident load-use is not a stall.
  assign w_stall_inc = ~rst & (w_mem_hold | (w_load_use & ~EX_BranchTaken));
  assign w_flush_inc = ~rst & ~w_mem_hold & EX_BranchTaken;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    PC_Write    = 1'b1;
    IFID_Write  = 1'b1;
    IFID_Flush  = 1'b0;
    IDEX_Flush  = 1'b0;
    EXMEM_Write = 1'b1;
    MEMWB_Write = 1'b1;

    case (r_state)
      RUN:      if (w_mem_hold) w_state_nxt = MEM_WAIT;
      MEM_WAIT: if (!w_mem_hold) w_state_nxt = RUN;
      default:  w_state_nxt = RUN;
    endcase

    if (rst) begin
      w_state_nxt = RUN;
      PC_Write    = 1'b0;
      IFID_Write  = 1'b0;
      IFID_Flush  = 1'b1;
      IDEX_Flush  = 1'b1;
      EXMEM_Write = 1'b0;
      MEMWB_Write = 1'b0;
    end else if (w_mem_hold) begin
      PC_Write    = 1'b0;
      IFID_Write  = 1'b0;
      EXMEM_Write = 1'b0;
      MEMWB_Write = 1'b0;
    end else if (EX_BranchTaken) begin
      IFID_Flush  = 1'b1;
      IDEX_Flush  = 1'b1;
    end else if (w_load_use) begin
      PC_Write    = 1'b0;
      IFID_Write  = 1'b0;
      IDEX_Flush  = 1'b1;
    end
  end

  // Wait timer counts every held cycle, including the one that enters MEM_WAIT.
  assign w_wait_inc = (r_wait_cnt == '1) ? r_wait_cnt : r_wait_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt    <= '0;
      r_mem_timeout <= 1'b0;
    end else if (w_mem_hold) begin
      r_wait_cnt <= w_wait_inc;
      if (w_wait_inc >= WAIT_LIM) r_mem_timeout <= 1'b1;
    end else begin
      r_wait_cnt <= '0;
    end
  end

  assign mem_timeout = r_mem_timeout;

  sat_counter #(.W(COUNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (w_stall_inc),
    .cnt (stall_cnt)
  );

  sat_counter #(.W(COUNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (w_flush_inc),
    .cnt (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench: directed per-cycle vectors push expected outputs; a negedge monitor checks them.
module tb_hazard_stall_unit;

  localparam int CW = 4;

  localparam logic [5:0] NORM = 6'b110011;
  localparam logic [5:0] RSTO = 6'b001100;
  localparam logic [5:0] HOLD = 6'b000000;
  localparam logic [5:0] BR   = 6'b111111;
  localparam logic [5:0] LU   = 6'b000111;

  typedef struct packed {
    logic [5:0]    ctrl;
    logic          tmo;
    logic [CW-1:0] stall;
    logic [CW-1:0] flush;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] ID_rs1 = '0, ID_rs2 = '0, EX_rd = '0;
  logic ID_use_rs1 = 0, ID_use_rs2 = 0, EX_MemRead = 0, EX_BranchTaken = 0;
  logic MEM_Req = 0, dmem_ready = 0;
  logic PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, EXMEM_Write, MEMWB_Write, mem_timeout;
  logic [CW-1:0] stall_cnt, flush_cnt;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  hazard_stall_unit #(.COUNT_W(CW), .WAIT_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_use_rs1(ID_use_rs1), .ID_use_rs2(ID_use_rs2),
    .EX_MemRead(EX_MemRead), .EX_rd(EX_rd), .EX_BranchTaken(EX_BranchTaken),
    .MEM_Req(MEM_Req), .dmem_ready(dmem_ready),
    .PC_Write(PC_Write), .IFID_Write(IFID_Write), .IFID_Flush(IFID_Flush),
    .IDEX_Flush(IDEX_Flush), .EXMEM_Write(EXMEM_Write), .MEMWB_Write(MEMWB_Write),
    .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic cyc(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic u1, input logic u2, input logic mr, input logic [4:0] rd,
                     input logic br, input logic req, input logic rdy,
                     input logic [5:0] ec, input logic et,
                     input logic [CW-1:0] es, input logic [CW-1:0] ef);
    exp_t e;
    rst = r; ID_rs1 = rs1; ID_rs2 = rs2; ID_use_rs1 = u1; ID_use_rs2 = u2;
    EX_MemRead = mr; EX_rd = rd; EX_BranchTaken = br; MEM_Req = req; dmem_ready = rdy;
    e.ctrl = ec; e.tmo = et; e.stall = es; e.flush = ef;
    q.push_back(e);
    @(posedge clk); #1;
  endtask

  // Monitor: the controller answers every cycle, so each negedge consumes one entry.
  initial begin
    exp_t e;
    logic [5:0] act;
    int cyc_n;
    cyc_n = 0;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        act = {PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, EXMEM_Write, MEMWB_Write};
        total++;
        if (act !== e.ctrl) begin
          bad++;
          $display("FAIL ctrl cyc=%0d got=%b want=%b", cyc_n, act, e.ctrl);
        end
        total++;
        if (mem_timeout !== e.tmo) begin
          bad++;
          $display("FAIL mem_timeout cyc=%0d got=%b want=%b", cyc_n, mem_timeout, e.tmo);
        end
        total++;
        if (stall_cnt !== e.stall) begin
          bad++;
          $display("FAIL stall_cnt cyc=%0d got=%0d want=%0d", cyc_n, stall_cnt, e.stall);
        end
        total++;
        if (flush_cnt !== e.flush) begin
          bad++;
          $display("FAIL flush_cnt cyc=%0d got=%0d want=%0d", cyc_n, flush_cnt, e.flush);
        end
        cyc_n++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk); #1;
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, RSTO, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, 0, 0, 0);
    // load-use on rs1, then the load has moved on
    cyc(0, 5, 0, 1, 0, 1, 5, 0, 0, 0, LU,   0, 0, 0);
    cyc(0, 5, 0, 1, 0, 0, 5, 0, 0, 0, NORM, 0, 1, 0);
    // x0 never stalls; unused operand never stalls; used rs2 does
    cyc(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, NORM, 0, 1, 0);
    cyc(0, 0, 7, 0, 0, 1, 7, 0, 0, 0, NORM, 0, 1, 0);
    cyc(0, 0, 7, 0, 1, 1, 7, 0, 0, 0, LU,   0, 1, 0);
    // branch beats load-use
    cyc(0, 5, 0, 1, 0, 1, 5, 1, 0, 0, BR,   0, 2, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, 0, 2, 1);
    // memory wait beats branch and load-use; branch acts on release
    for (int i = 0; i < 3; i++)
      cyc(0, 5, 0, 1, 0, 1, 5, 1, 1, 0, HOLD, 0, CW'(2 + i), 1);
    cyc(0, 5, 0, 1, 0, 1, 5, 1, 1, 1, BR,   0, 5, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, 0, 5, 2);
    // timeout after 4 held cycles, sticky past release
    for (int i = 0; i < 6; i++)
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, HOLD, (i >= 4), CW'(5 + i), 2);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, NORM, 1, 11, 2);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, 1, 11, 2);
    // stall counter saturates at all-ones
    for (int i = 0; i < 6; i++)
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, HOLD, 1, (11 + i > 15) ? CW'(15) : CW'(11 + i), 2);
    // reset in the middle of a wait
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, RSTO, 1, 15, 2);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, 0, 0, 0);
    cyc(0, 3, 0, 1, 0, 1, 3, 0, 0, 0, LU,   0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, 0, 1, 0);

    repeat (3) @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain left=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Producer-side hazard controller for the 5-stage pipeline. It decides when the pipeline must stall, bubble or flush.
- It handles the cases the forwarding path cannot resolve:
  - load-use in ID against a load in EX;
  - taken branch resolved in EX;
  - data-memory wait in MEM.
- Drives the PC and pipeline-register write enables and flushes. Keeps a memory-wait timer, a timeout flag and stall/flush performance counters.

Parameters:
- COUNT_W, 16, width of the saturating stall and flush counters.
- WAIT_MAX, 255, MEM_WAIT cycles after which the timeout flag is set (maximum 65535).

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- ID_rs1  in  5  source register 1 of the instruction in ID.
- ID_rs2  in  5  source register 2 of the instruction in ID.
- ID_use_rs1  in  1  the ID instruction reads rs1.
- ID_use_rs2  in  1  the ID instruction reads rs2.
- EX_MemRead  in  1  the ID/EX instruction is a load.
- EX_rd  in  5  destination register of the ID/EX instruction.
- EX_BranchTaken  in  1  branch/jump resolved taken in EX this cycle.
- MEM_Req  in  1  the EX/MEM instruction accesses data memory.
- dmem_ready  in  1  data memory completes the access this cycle.
- PC_Write  out  1  PC load enable.
- IFID_Write  out  1  IF/ID register enable.
- IFID_Flush  out  1  zero IF/ID (insert NOP).
- IDEX_Flush  out  1  zero ID/EX control (bubble).
- EXMEM_Write  out  1  EX/MEM register enable.
- MEMWB_Write  out  1  MEM/WB register enable.
- mem_timeout  out  1  sticky, memory wait exceeded WAIT_MAX.
- stall_cnt  out  COUNT_W  saturating count of stalled cycles.
- flush_cnt  out  COUNT_W  saturating count of branch flushes.

Behaviour:
- States:
  - RUN and MEM_WAIT.
  - State register and counters are clocked.
  - Control outputs are combinational from state and inputs (Mealy), so they act in the same cycle as the hazard.
- Definitions:
  - mem_hold = MEM_Req & ~dmem_ready.
  - load_use = EX_MemRead & (EX_rd != 0) & ((ID_use_rs1 & ID_rs1 == EX_rd) | (ID_use_rs2 & ID_rs2 == EX_rd)).
- Priority, highest first:
  - rst
  - mem_hold
  - EX_BranchTaken
  - load_use
  - normal
- rst=1:
  - next state RUN; wait timer, stall_cnt, flush_cnt and mem_timeout cleared to 0.
  - Outputs this cycle: PC_Write=0, IFID_Write=0, EXMEM_Write=0, MEMWB_Write=0, IFID_Flush=1, IDEX_Flush=1.
  - Reset mid-MEM_WAIT aborts the wait unconditionally.
- Normal (no hazard):
  - all write enables = 1;
  - both flushes = 0.
- mem_hold, in either state:
  - all four write enables = 0, flushes = 0 (whole pipeline frozen);
  - next state MEM_WAIT;
  - stall_cnt += 1.
  - The branch and load-use conditions are ignored this cycle and re-evaluated after release, because their inputs are held constant by the freeze.
- MEM_WAIT:
  - wait timer increments each cycle while mem_hold = 1.
  - The cycle the timer reaches WAIT_MAX, mem_timeout is set to 1. It stays set until rst, and the wait continues.
  - Exit on dmem_ready=1:
    - that cycle uses the normal, branch or load-use outputs per priority;
    - next state RUN; wait timer cleared.
- EX_BranchTaken, not held:
  - IFID_Flush=1, IDEX_Flush=1, all write enables = 1 (PC loads the target);
  - flush_cnt += 1.
  - A simultaneous load_use is discarded, since the ID instruction is squashed; stall_cnt is not incremented.
- load_use, not held, no branch:
  - PC_Write=0, IFID_Write=0, IDEX_Flush=1, IFID_Flush=0, EXMEM_Write=1, MEMWB_Write=1;
  - stall_cnt += 1.
  - Exactly one bubble: next cycle the load has moved to MEM, so load_use deasserts and forwarding covers the rest.
- x0 never causes a stall (EX_rd == 0 excluded).
- Counters saturate at all-ones; no wrap-around.
- Latency: zero-cycle combinational response; state and counters update on the next edge.

Decomposition:
- hazard_pkg holds:
  - state enum (RUN, MEM_WAIT);
  - register-index width constant REG_W=5;
  - constant ZERO_REG=5'd0.
- One natural sub-module, sat_counter (parameter W, inputs clk, rst, inc; output cnt). It is instantiated for stall_cnt and flush_cnt. The wait timer is inline.

Test Plan:
- Load-use: EX_MemRead=1, EX_rd=5, ID_rs1=5, ID_use_rs1=1 -> one cycle of PC_Write=0, IFID_Write=0, IDEX_Flush=1; stall_cnt 0->1; next cycle all enables 1.
- x0 / unused operand: EX_rd=0 with ID_rs1=0, and separately EX_rd=7, ID_rs2=7, ID_use_rs2=0 -> no stall, all enables 1.
- Branch vs load-use: EX_BranchTaken=1 together with a load_use match -> IFID_Flush=1, IDEX_Flush=1, PC_Write=1; flush_cnt=1, stall_cnt=0.
- Memory wait: MEM_Req=1, dmem_ready=0 for 3 cycles then 1 -> 3 cycles with all four enables 0 and state MEM_WAIT; stall_cnt=3; RUN after the ready edge.
- Timeout: WAIT_MAX=4, dmem_ready held 0 for 6 cycles -> mem_timeout rises at the 4th wait cycle and stays 1 after dmem_ready; cleared only by rst.
- Reset mid-wait: rst=1 during MEM_WAIT -> outputs at reset values, counters 0, mem_timeout 0; with no hazards the next cycle after rst deasserts shows all enables 1 in RUN.
